// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writeback.
// Optional WB_RR_ARB_EN: round-robin grant between contested sources on an empty queue.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ALU_REQ,
  input  logic [AW-1:0]          ALU_A3,
  input  logic [DW-1:0]          ALU_WD,
  output logic                   ALU_RDY,
  input  logic                   MEM_REQ,
  input  logic [AW-1:0]          MEM_A3,
  input  logic [DW-1:0]          MEM_WD,
  output logic                   MEM_RDY,
  output logic                   WE3,
  output logic [AW-1:0]          A3,
  output logic [DW-1:0]          WD3,
  input  logic [AW-1:0]          A1,
  input  logic [AW-1:0]          A2,
  output logic                   HAZ1,
  output logic                   HAZ2,
  output logic [(1<<AW)-1:0]     PEND,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RDY_MAX  = CW'(DEPTH - 2);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    tail1;
  logic [CW-1:0]    cnt;

  logic          rdy;
  logic          alu_acc;
  logic          mem_acc;
  logic          q_busy;
  logic          alu_first;
  logic          sel_q;
  logic          sel_mem;
  logic          sel_alu;
  logic          pop;
  logic          iss_v;
  logic [AW-1:0] iss_a;
  logic [DW-1:0] iss_d;
  logic          push_mem;
  logic          push_alu;
  logic          wr0_v;
  logic          wr1_v;
  logic [AW-1:0] wr0_a;
  logic [DW-1:0] wr0_d;
  logic          sh_v;
  logic [AW-1:0] sh_a;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign rdy     = (cnt <= RDY_MAX);
  assign ALU_RDY = rdy;
  assign MEM_RDY = rdy;
  assign alu_acc = ALU_REQ & rdy;
  assign mem_acc = MEM_REQ & rdy;
  assign q_busy  = (cnt != '0);
  assign tail1   = inc(tail);
  assign COUNT   = cnt;

`ifdef WB_RR_ARB_EN
  logic rr;
  logic contested;
  assign contested = ~q_busy & mem_acc & alu_acc;
  assign alu_first = contested & rr;
  // Round-robin pointer flips on each contested grant; 0 means MEM first.
  always_ff @(posedge CLK) begin
    if (RST) rr <= 1'b0;
    else if (contested) rr <= ~rr;
  end
`else
  assign alu_first = 1'b0;
`endif

  assign sel_q   = q_busy;
  assign sel_mem = ~q_busy & mem_acc & ~alu_first;
  assign sel_alu = ~q_busy & alu_acc & (~mem_acc | alu_first);

  // Pick the write to issue and which accepted requests fall into the queue.
  always_comb begin
    pop      = 1'b0;
    iss_v    = 1'b0;
    iss_a    = q_addr[head];
    iss_d    = q_data[head];
    push_mem = 1'b0;
    push_alu = 1'b0;
    unique case (1'b1)
      sel_q: begin
        pop      = 1'b1;
        iss_v    = 1'b1;
        push_mem = mem_acc;
        push_alu = alu_acc;
      end
      sel_mem: begin
        iss_v    = 1'b1;
        iss_a    = MEM_A3;
        iss_d    = MEM_WD;
        push_alu = alu_acc;
      end
      sel_alu: begin
        iss_v    = 1'b1;
        iss_a    = ALU_A3;
        iss_d    = ALU_WD;
        push_mem = mem_acc;
      end
      default: ;
    endcase
  end

  assign wr0_v = push_mem | push_alu;
  assign wr1_v = push_mem & push_alu;
  assign wr0_a = push_mem ? MEM_A3 : ALU_A3;
  assign wr0_d = push_mem ? MEM_WD : ALU_WD;

  // Next slot-valid vector: retire the head, claim one or two tail slots.
  always_comb begin
    vld_nxt = q_vld;
    if (pop) vld_nxt[head] = 1'b0;
    if (wr0_v) vld_nxt[tail] = 1'b1;
    if (wr1_v) vld_nxt[tail1] = 1'b1;
  end

  // Queue pointers, occupancy and slot-valid bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      q_vld <= '0;
    end else begin
      q_vld <= vld_nxt;
      cnt   <= cnt + CW'(wr0_v) + CW'(wr1_v) - CW'(pop);
      if (pop) head <= inc(head);
      if (wr1_v) tail <= inc(tail1);
      else if (wr0_v) tail <= tail1;
    end
  end

  // Queue payload storage; MEM lands ahead of ALU when both are pushed.
  always_ff @(posedge CLK) begin
    if (wr0_v) begin
      q_addr[tail] <= wr0_a;
      q_data[tail] <= wr0_d;
    end
    if (wr1_v) begin
      q_addr[tail1] <= ALU_A3;
      q_data[tail1] <= ALU_WD;
    end
  end

  // Registered write port plus the shadow of last cycle's write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WE3  <= 1'b0;
      A3   <= '0;
      WD3  <= '0;
      sh_v <= 1'b0;
      sh_a <= '0;
    end else begin
      WE3  <= iss_v;
      sh_v <= WE3;
      sh_a <= A3;
      if (iss_v) begin
        A3  <= iss_a;
        WD3 <= iss_d;
      end
    end
  end

  // Pending mask: queued entries, the write port and the shadow stage.
  always_comb begin
    PEND = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) PEND[q_addr[i]] = 1'b1;
    end
    if (WE3) PEND[A3] = 1'b1;
    if (sh_v) PEND[sh_a] = 1'b1;
  end

  assign HAZ1 = PEND[A1];
  assign HAZ2 = PEND[A2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks of regfile_wb_arbiter
// against a queue-based model of accepted-but-unwritten writes.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ALU_REQ = 1'b0;
  logic [3:0]  ALU_A3 = '0;
  logic [15:0] ALU_WD = '0;
  logic        ALU_RDY;
  logic        MEM_REQ = 1'b0;
  logic [3:0]  MEM_A3 = '0;
  logic [15:0] MEM_WD = '0;
  logic        MEM_RDY;
  logic        WE3;
  logic [3:0]  A3;
  logic [15:0] WD3;
  logic [3:0]  A1 = '0;
  logic [3:0]  A2 = '0;
  logic        HAZ1;
  logic        HAZ2;
  logic [15:0] PEND;
  logic [2:0]  COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_REQ(ALU_REQ), .ALU_A3(ALU_A3), .ALU_WD(ALU_WD), .ALU_RDY(ALU_RDY),
    .MEM_REQ(MEM_REQ), .MEM_A3(MEM_A3), .MEM_WD(MEM_WD), .MEM_RDY(MEM_RDY),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .HAZ1(HAZ1), .HAZ2(HAZ2),
    .PEND(PEND), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  // Model: every accepted write not yet on the port, in issue order.
  wr_t         mq[$];
  logic        m_we;
  logic [3:0]  m_a;
  logic [15:0] m_d;
  logic        m_sh_v;
  logic [3:0]  m_sh_a;
  logic        m_rr;

  function automatic logic [15:0] m_pend();
    logic [15:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (m_we) p[m_a] = 1'b1;
    if (m_sh_v) p[m_sh_a] = 1'b1;
    return p;
  endfunction

  function automatic logic [43:0] m_obs();
    logic [15:0] p;
    logic        r;
    p = m_pend();
    r = (mq.size() <= DEPTH - 2);
    return {m_we, m_a, m_d, 3'(mq.size()), p, p[A1], p[A2], r, r};
  endfunction

  function automatic logic [43:0] dut_obs();
    return {WE3, A3, WD3, COUNT, PEND, HAZ1, HAZ2, ALU_RDY, MEM_RDY};
  endfunction

  task automatic step(input logic rst,
                      input logic ar, input logic [3:0] aa, input logic [15:0] ad,
                      input logic mr, input logic [3:0] ma, input logic [15:0] md);
    bit  acc;
    bit  alu_first;
    wr_t w;
    RST = rst;
    ALU_REQ = ar; ALU_A3 = aa; ALU_WD = ad;
    MEM_REQ = mr; MEM_A3 = ma; MEM_WD = md;
    @(posedge CLK);
    if (rst) begin
      mq.delete();
      m_we = 0; m_a = '0; m_d = '0;
      m_sh_v = 0; m_sh_a = '0; m_rr = 0;
    end else begin
      acc = (mq.size() <= DEPTH - 2);
      alu_first = 0;
`ifdef WB_RR_ARB_EN
      if (mq.size() == 0 && acc && ar && mr) begin
        alu_first = m_rr;
        m_rr = !m_rr;
      end
`endif
      if (alu_first) begin
        mq.push_back('{aa, ad});
        mq.push_back('{ma, md});
      end else begin
        if (acc && mr) mq.push_back('{ma, md});
        if (acc && ar) mq.push_back('{aa, ad});
      end
      m_sh_v = m_we;
      m_sh_a = m_a;
      if (mq.size() > 0) begin
        w = mq.pop_front();
        m_we = 1; m_a = w.a; m_d = w.d;
      end else begin
        m_we = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_reset();
    step(1, 0, '0, '0, 0, '0, '0);
    step(1, 0, '0, '0, 0, '0, '0);
    step(0, 1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222);
    step(0, 1, 4'd3, 16'h3333, 1, 4'd4, 16'h4444);
    step(1, 1, 4'd7, 16'h7777, 0, '0, '0);
    n_tests++;
    if ({WE3, COUNT, PEND, ALU_RDY, MEM_RDY} !== {1'b0, 3'd0, 16'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b cnt=%0d pend=%h rdy=%b%b want 0/0/0000/11",
               WE3, COUNT, PEND, ALU_RDY, MEM_RDY);
    end
    n_tests++;
    if ({A3, WD3} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_port: got a3=%h wd3=%h want 0/0000", A3, WD3);
    end
    idle(1);
    n_tests++;
    if ({WE3, COUNT} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got we=%b cnt=%0d want 0/0", WE3, COUNT);
    end
  endtask

  task automatic test_single();
    idle(3);
    A1 = 4'd5;
    step(0, 1, 4'd5, 16'h1234, 0, '0, '0);
    n_tests++;
    if ({WE3, A3, WD3, PEND[5], HAZ1} !== {1'b1, 4'd5, 16'h1234, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_issue: got we=%b a3=%0d wd3=%h pend5=%b haz1=%b want 1/5/1234/1/1",
               WE3, A3, WD3, PEND[5], HAZ1);
    end
    idle(1);
    n_tests++;
    if ({WE3, PEND[5], HAZ1} !== 3'b011) begin
      n_fail++;
      $display("FAIL single_shadow: got we=%b pend5=%b haz1=%b want 0/1/1", WE3, PEND[5], HAZ1);
    end
    idle(1);
    n_tests++;
    if ({PEND[5], HAZ1} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_clear: got pend5=%b haz1=%b want 0/0", PEND[5], HAZ1);
    end
  endtask

  task automatic test_collision();
    idle(3);
    A2 = 4'd3;
    step(0, 1, 4'd3, 16'h5555, 1, 4'd3, 16'hAAAA);
    n_tests++;
    if ({WE3, A3, WD3, COUNT, PEND[3], HAZ2} !== {1'b1, 4'd3, 16'hAAAA, 3'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL collide_first: got we=%b a3=%0d wd3=%h cnt=%0d pend3=%b want 1/3/aaaa/1/1",
               WE3, A3, WD3, COUNT, PEND[3]);
    end
    idle(1);
    n_tests++;
    if ({WE3, A3, WD3, COUNT, PEND[3]} !== {1'b1, 4'd3, 16'h5555, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL collide_second: got we=%b a3=%0d wd3=%h cnt=%0d pend3=%b want 1/3/5555/0/1",
               WE3, A3, WD3, COUNT, PEND[3]);
    end
    idle(1);
    n_tests++;
    if ({WE3, PEND[3]} !== 2'b01) begin
      n_fail++;
      $display("FAIL collide_shadow: got we=%b pend3=%b want 0/1", WE3, PEND[3]);
    end
    idle(1);
    n_tests++;
    if (PEND[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_clear: got pend3=%b want 0", PEND[3]);
    end
  endtask

  task automatic test_backpressure();
    bit saw_full;
    saw_full = 0;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4'($urandom), 16'($urandom), 1, 4'($urandom), 16'($urandom));
      A1 = 4'($urandom); A2 = 4'($urandom); #1;
      n_tests++;
      if (dut_obs() !== m_obs()) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got %h want %h", i, dut_obs(), m_obs());
      end
      if (COUNT == 3'd3 && !ALU_RDY && !MEM_RDY) saw_full = 1;
      n_tests++;
      if (COUNT > 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL bp_bound: got count %0d want <= %0d", COUNT, DEPTH);
      end
    end
    n_tests++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL bp_ready_drop: got no cycle with count 3 and rdy 0, want one");
    end
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n_tests++;
      if (dut_obs() !== m_obs()) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got %h want %h", i, dut_obs(), m_obs());
      end
    end
  endtask

  task automatic test_wrap();
    wr_t src[20];
    wr_t got[$];
    int  sent;
    int  cyc;
    bit  r;
    for (int i = 0; i < 20; i++) src[i] = '{4'(i % 16), 16'($urandom)};
    idle(3);
    sent = 0;
    cyc = 0;
    while ((sent < 20 || got.size() < 20) && cyc < 100) begin
      r = (mq.size() <= DEPTH - 2);
      if (r && sent < 19)
        step(0, 1, src[sent+1].a, src[sent+1].d, 1, src[sent].a, src[sent].d);
      else if (r && sent == 19)
        step(0, 0, '0, '0, 1, src[sent].a, src[sent].d);
      else
        step(0, 0, '0, '0, 0, '0, '0);
      if (r) sent = (sent < 19) ? sent + 2 : 20;
      if (WE3) got.push_back('{A3, WD3});
      cyc++;
      n_tests++;
      if (dut_obs() !== m_obs()) begin
        n_fail++;
        $display("FAIL wrap_cycle%0d: got %h want %h", cyc, dut_obs(), m_obs());
      end
    end
    n_tests++;
    if (got.size() != 20) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes want 20", got.size());
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== src[i]) begin
        n_fail++;
        $display("FAIL wrap_order%0d: got %h want %h", i, got[i], src[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 59) == 0),
           1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 4'($urandom), 16'($urandom));
      A1 = 4'($urandom); A2 = 4'($urandom); #1;
      n_tests++;
      if (dut_obs() !== m_obs()) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %h want %h", i, dut_obs(), m_obs());
      end
    end
  endtask

`ifdef WB_RR_ARB_EN
  task automatic test_rr();
    logic [15:0] want[3];
    step(1, 0, '0, '0, 0, '0, '0);
    want[0] = 16'hA000; want[1] = 16'hB001; want[2] = 16'hA002;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'd9, 16'hB000 + 16'(i), 1, 4'd8, 16'hA000 + 16'(i));
      n_tests++;
      if ({WE3, WD3} !== {1'b1, want[i]}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got we=%b wd3=%h want 1/%h", i, WE3, WD3, want[i]);
      end
      idle(2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_backpressure();
    test_wrap();
    test_random();
`ifdef WB_RR_ARB_EN
    test_rr();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) between two writeback sources: ALU results and memory loads.
- Buffers writes it cannot issue in an in-order FIFO and issues one write per cycle.
- Exports a per-register pending-write mask and read-hazard flags so the decode stage can stall on operands not yet written.
- Sits between the execute/memory stages and the register file; its outputs drive the register file write port directly.

Parameters:
- DEPTH, 4, pending-write FIFO entries; legal range 2..16.
- AW, 4, register address width (16 registers).
- DW, 16, data width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous active-high reset.
- ALU_REQ  input  1  ALU writeback request.
- ALU_A3  input  AW  ALU destination register.
- ALU_WD  input  DW  ALU result.
- ALU_RDY  output  1  ALU request accepted when ALU_REQ && ALU_RDY.
- MEM_REQ  input  1  load writeback request.
- MEM_A3  input  AW  load destination register.
- MEM_WD  input  DW  load data.
- MEM_RDY  output  1  load request accepted when MEM_REQ && MEM_RDY.
- WE3  output  1  register file write enable (registered).
- A3  output  AW  register file write address (registered).
- WD3  output  DW  register file write data (registered).
- A1  input  AW  decode read address 1.
- A2  input  AW  decode read address 2.
- HAZ1  output  1  pending write to A1 (combinational).
- HAZ2  output  1  pending write to A2 (combinational).
- PEND  output  2^AW  pending-write bitmask.
- COUNT  output  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: RST is sampled at the rising edge of CLK only. It clears the FIFO (COUNT=0), sets WE3=0, A3=0, WD3=0, clears the shadow stage, and sets PEND=0. ALU_RDY=MEM_RDY=1 in the first cycle after reset. Queued and in-flight writes are discarded when reset is asserted mid-operation.
- Ready: ALU_RDY = MEM_RDY = (COUNT <= DEPTH-2). Ready depends only on registered occupancy, never on the REQ inputs, so there are no combinational loops. Two accepts in one cycle can never overflow the FIFO.
- Issue selection each cycle, in priority order:
  1. FIFO head, if COUNT>0.
  2. Otherwise the accepted MEM request.
  3. Otherwise the accepted ALU request.
- The selected entry is registered into WE3/A3/WD3 at the next edge. With no candidate, WE3=0 and A3/WD3 hold their previous values.
- Enqueue: accepted requests that are not issued are pushed to the FIFO tail, MEM before ALU within the same cycle. Up to two pushes and one pop occur per cycle.
- Ordering: writes issue in acceptance order; same-cycle order is MEM then ALU. If both target the same register in one cycle, the ALU value is final.
- Latency:
  - Empty FIFO, accepted REQ at edge n: WE3=1 during cycle n+1. The value is readable from the register file at n+3, because the register file latches its write port for one cycle.
  - Queued entries add one cycle per entry ahead of them.
- Shadow stage: holds {valid=WE3, addr=A3} for one cycle after issue. This covers the register file's internal write latch.
- PEND bit r is set iff r matches any of:
  - a valid FIFO entry's address;
  - the output stage while WE3=1;
  - the valid shadow stage.
- HAZ1 = PEND[A1]; HAZ2 = PEND[A2]; both purely combinational.
- COUNT is never above DEPTH and never negative. Head/tail pointers wrap modulo DEPTH.
- Register r0 receives no special treatment; writes to it are arbitrated like any other.

Optional Feature:
- Macro WB_RR_ARB_EN.
- Defined: when the FIFO is empty and both sources are accepted in the same cycle, a 1-bit round-robin pointer picks the issued source. The other source is enqueued. The pointer toggles after every contested grant and resets to MEM-first.
- Not defined: fixed MEM-over-ALU priority as specified above.

Test Plan:
- Reset: assert RST with ALU_REQ=1 mid-stream -> next cycle WE3=0, COUNT=0, PEND=0, ALU_RDY=MEM_RDY=1. The queued write never appears on WE3.
- Single write: ALU_REQ with A3=5, WD=16'h1234, FIFO empty -> WE3=1, A3=5, WD3=16'h1234 one cycle later. PEND[5]=1 for exactly 2 cycles; HAZ1=1 when A1=5 during those cycles.
- Collision: MEM (r3, 16'hAAAA) and ALU (r3, 16'h5555) in the same cycle -> consecutive WE3 cycles: r3=AAAA, then r3=5555. COUNT peaks at 1. PEND[3] is held for 3 cycles.
- Backpressure, DEPTH=4: both REQ held high for 4 cycles -> RDY falls once COUNT reaches 3. No entry is lost or reordered; all accepted writes issue in order and COUNT never exceeds 4.
- Wrap-around: 20 alternating single writes to r0..r15 -> FIFO pointers wrap correctly and the output sequence matches the input sequence exactly.
- WB_RR_ARB_EN defined: three successive contested cycles with an empty FIFO -> issued sources are MEM, ALU, MEM.
